// File: rtl/io_timer.sv
// rtl/io_timer.sv - programmable down-counting timer on the processor I/O bus
//
// Optional build macro: IO_TIMER_IRQ_EN (adds CTRL.IE and the irq output)
//
// Ports:
//   clk      in   rising-edge system clock
//   reset    in   asynchronous active-low reset
//   dev_sel  in   3-bit device select (I/O address [4:2])
//   reg_sel  in   2-bit register select (I/O address [1:0])
//   data_in  in   16-bit write data
//   we       in   write strobe
//   data_out out  16-bit combinational read data, 0 when not selected
//   done     out  mirror of STATUS.DONE
//   irq      out  registered DONE && IE (IO_TIMER_IRQ_EN builds only)
//
// Registers: 0 CTRL {IE,AUTO,EN}, 1 LOAD, 2 COUNT, 3 STATUS {OVR,DONE} (W1C)

module io_timer #(
  parameter logic [2:0] DEV_ID   = 3'd2,
  parameter int         PRESCALE = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  dev_sel,
  input  logic [1:0]  reg_sel,
  input  logic [15:0] data_in,
  input  logic        we,
  output logic [15:0] data_out,
  output logic        done
`ifdef IO_TIMER_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(PRESCALE - 1);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic          en;
  logic          auto_r;
  logic          ie;
  logic [15:0]   load_r;
  logic [15:0]   count_r;
  logic          done_r;
  logic          ovr_r;
  logic [PW-1:0] pre;

  logic sel;
  logic wr_ctrl, wr_load, wr_count, wr_status;
  logic run, tick, expire, start;
  logic clr_done, clr_ovr;
  logic [15:0] rd_data;

  assign sel       = (dev_sel == DEV_ID);
  assign wr_ctrl   = sel && we && (reg_sel == REG_CTRL);
  assign wr_load   = sel && we && (reg_sel == REG_LOAD);
  assign wr_count  = sel && we && (reg_sel == REG_COUNT);
  assign wr_status = sel && we && (reg_sel == REG_STATUS);

  assign clr_done  = wr_status && data_in[0];
  assign clr_ovr   = wr_status && data_in[1];

  // Enabled with a zero count (e.g. AUTO reload of LOAD=0) is a parked state:
  // the prescaler stays at 0 and no ticks or expiries happen.
  assign run    = en && (count_r != 16'd0);
  assign tick   = run && (pre == PRE_MAX);
  assign expire = tick && (count_r == 16'd1);

  // IDLE -> RUN transition; a zero count picks up the reload value.
  assign start  = wr_ctrl && data_in[0] && !en;

  // Control register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en     <= 1'b0;
      auto_r <= 1'b0;
    end else if (wr_ctrl) begin
      en     <= data_in[0];
      auto_r <= data_in[1];
    end else if (expire && !auto_r) begin
      en     <= 1'b0;
    end
  end

`ifdef IO_TIMER_IRQ_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ie <= data_in[2];
      end
      irq <= done_r && ie;
    end
  end
`else
  assign ie = 1'b0;
`endif

  // Reload value; never touches COUNT on its own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_r <= 16'd0;
    end else if (wr_load) begin
      load_r <= data_in;
    end
  end

  // Counter: a CPU write beats a same-cycle tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= 16'd0;
    end else if (wr_count) begin
      count_r <= data_in;
    end else if (start) begin
      if (count_r == 16'd0) begin
        count_r <= load_r;
      end
    end else if (tick) begin
      if (count_r == 16'd1) begin
        count_r <= auto_r ? load_r : 16'd0;
      end else begin
        count_r <= count_r - 16'd1;
      end
    end
  end

  // Prescaler: cleared when not running and when a CTRL write starts or
  // stops the timer, so the first tick lands PRESCALE cycles after enable.
  // A CTRL write that leaves a running timer enabled does not disturb it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else if (!run || (wr_ctrl && (!data_in[0] || !en))) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Status: expiry beats a same-cycle W1C. OVR only counts an expiry that
  // lands on a DONE software has not tried to clear in that same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_r <= 1'b0;
      ovr_r  <= 1'b0;
    end else begin
      if (expire) begin
        done_r <= 1'b1;
      end else if (clr_done) begin
        done_r <= 1'b0;
      end

      if (expire && done_r && !clr_done) begin
        ovr_r <= 1'b1;
      end else if (clr_ovr) begin
        ovr_r <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = 16'd0;
    case (reg_sel)
      REG_CTRL:   rd_data = {13'd0, ie, auto_r, en};
      REG_LOAD:   rd_data = load_r;
      REG_COUNT:  rd_data = count_r;
      REG_STATUS: rd_data = {14'd0, ovr_r, done_r};
      default:    rd_data = 16'd0;
    endcase
  end

  assign data_out = sel ? rd_data : 16'd0;
  assign done     = done_r;

endmodule

// File: tb/tb_io_timer.sv
// tb/tb_io_timer.sv - directed table and sequence checks for io_timer
module tb_io_timer;

  localparam int         PRE = 4;
  localparam logic [2:0] DEV = 3'd2;

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_LOAD   = 2'd1;
  localparam logic [1:0] R_COUNT  = 2'd2;
  localparam logic [1:0] R_STATUS = 2'd3;

`ifdef IO_TIMER_IRQ_EN
  localparam logic [15:0] CTRL_FFFE_RD = 16'h0006;
`else
  localparam logic [15:0] CTRL_FFFE_RD = 16'h0002;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  dev_sel;
  logic [1:0]  reg_sel;
  logic [15:0] data_in;
  logic        we;
  logic [15:0] data_out;
  logic        done;
`ifdef IO_TIMER_IRQ_EN
  logic        irq;
`endif

  io_timer #(.DEV_ID(DEV), .PRESCALE(PRE)) dut (
    .clk      (clk),
    .reset    (reset),
    .dev_sel  (dev_sel),
    .reg_sel  (reg_sel),
    .data_in  (data_in),
    .we       (we),
    .data_out (data_out),
    .done     (done)
`ifdef IO_TIMER_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [2:0]  dev;
    logic [1:0]  rs;
    logic        w;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; write is captured on the next posedge and the task
  // returns at the following negedge.
  task automatic wr(input logic [1:0] r, input logic [15:0] d);
    dev_sel = DEV;
    reg_sel = r;
    data_in = d;
    we      = 1'b1;
    @(negedge clk);
    we      = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] r, input logic [15:0] exp);
    dev_sel = DEV;
    reg_sel = r;
    #1;
    check(name, data_out, exp);
  endtask

  task automatic done_chk(input string name, input logic exp);
    #1;
    check(name, {15'd0, done}, {15'd0, exp});
  endtask

`ifdef IO_TIMER_IRQ_EN
  task automatic irq_chk(input string name, input logic exp);
    #1;
    check(name, {15'd0, irq}, {15'd0, exp});
  endtask
`endif

  initial begin
    reset   = 1'b0;
    dev_sel = 3'd0;
    reg_sel = 2'd0;
    data_in = 16'd0;
    we      = 1'b0;

    //           dev   rs        we    din       expected read
    vecs[0]  = '{3'd2, R_CTRL,   1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{3'd2, R_LOAD,   1'b1, 16'h1234, 16'h1234};
    vecs[2]  = '{3'd3, R_LOAD,   1'b1, 16'hBEEF, 16'h0000};
    vecs[3]  = '{3'd2, R_LOAD,   1'b0, 16'h0000, 16'h1234};
    vecs[4]  = '{3'd5, R_LOAD,   1'b0, 16'h0000, 16'h0000};
    vecs[5]  = '{3'd2, R_CTRL,   1'b1, 16'hFFFE, CTRL_FFFE_RD};
    vecs[6]  = '{3'd2, R_COUNT,  1'b1, 16'h00AB, 16'h00AB};
    vecs[7]  = '{3'd2, R_STATUS, 1'b1, 16'hFFFF, 16'h0000};
    vecs[8]  = '{3'd0, R_COUNT,  1'b0, 16'h0000, 16'h0000};
    vecs[9]  = '{3'd2, R_CTRL,   1'b1, 16'h0000, 16'h0000};
    vecs[10] = '{3'd2, R_COUNT,  1'b1, 16'h0000, 16'h0000};
    vecs[11] = '{3'd2, R_LOAD,   1'b1, 16'h0000, 16'h0000};

    // Reset state
    step(2);
    rd_chk("rst_ctrl",   R_CTRL,   16'h0);
    rd_chk("rst_load",   R_LOAD,   16'h0);
    rd_chk("rst_count",  R_COUNT,  16'h0);
    rd_chk("rst_status", R_STATUS, 16'h0);
    done_chk("rst_done", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step(1);

    // Register access and decode table
    for (int i = 0; i < 12; i++) begin
      dev_sel = vecs[i].dev;
      reg_sel = vecs[i].rs;
      data_in = vecs[i].din;
      we      = vecs[i].w;
      if (vecs[i].w) begin
        @(negedge clk);
        we = 1'b0;
      end
      #1;
      check($sformatf("vec%0d_data", i), data_out, vecs[i].exp);
      check($sformatf("vec%0d_done", i), {15'd0, done}, 16'd0);
      @(negedge clk);
    end

    // One-shot: LOAD=3, expiry 12 cycles after the enable edge
    wr(R_LOAD, 16'd3);
    wr(R_CTRL, 16'd1);
    rd_chk("os_k0_count", R_COUNT, 16'd3);
    step(3);
    rd_chk("os_k3_count", R_COUNT, 16'd3);
    step(1);
    rd_chk("os_k4_count", R_COUNT, 16'd2);
    step(4);
    rd_chk("os_k8_count", R_COUNT, 16'd1);
    step(3);
    rd_chk("os_k11_count", R_COUNT, 16'd1);
    done_chk("os_k11_done", 1'b0);
    step(1);
    rd_chk("os_k12_count", R_COUNT, 16'd0);
    rd_chk("os_k12_status", R_STATUS, 16'd1);
    rd_chk("os_k12_ctrl", R_CTRL, 16'd0);
    done_chk("os_k12_done", 1'b1);
    step(8);
    rd_chk("os_after_count", R_COUNT, 16'd0);
    rd_chk("os_after_status", R_STATUS, 16'd1);
    wr(R_STATUS, 16'd3);
    rd_chk("os_clr_status", R_STATUS, 16'd0);

    // Auto-reload with DONE left set: second expiry raises OVR
    wr(R_LOAD, 16'd2);
    wr(R_CTRL, 16'd3);
    rd_chk("ar_k0_count", R_COUNT, 16'd2);
    step(7);
    rd_chk("ar_k7_count", R_COUNT, 16'd1);
    rd_chk("ar_k7_status", R_STATUS, 16'd0);
    step(1);
    rd_chk("ar_k8_count", R_COUNT, 16'd2);
    rd_chk("ar_k8_status", R_STATUS, 16'd1);
    rd_chk("ar_k8_ctrl", R_CTRL, 16'd3);
    step(7);
    rd_chk("ar_k15_status", R_STATUS, 16'd1);
    step(1);
    rd_chk("ar_k16_status", R_STATUS, 16'd3);
    rd_chk("ar_k16_count", R_COUNT, 16'd2);
    wr(R_STATUS, 16'd3);
    rd_chk("ar_w1c_status", R_STATUS, 16'd0);
    wr(R_CTRL, 16'd0);
    rd_chk("ar_stop_ctrl", R_CTRL, 16'd0);
    rd_chk("ar_stop_count", R_COUNT, 16'd2);
    step(10);
    rd_chk("ar_idle_count", R_COUNT, 16'd2);
    rd_chk("ar_idle_status", R_STATUS, 16'd0);

    // Collision: W1C of DONE on the expiry edge, then COUNT write on a tick
    wr(R_CTRL, 16'd3);
    step(8);
    rd_chk("co_k8_status", R_STATUS, 16'd1);
    step(7);
    wr(R_STATUS, 16'd1);
    rd_chk("co_w1c_status", R_STATUS, 16'd1);
    rd_chk("co_w1c_count", R_COUNT, 16'd2);
    step(3);
    wr(R_COUNT, 16'd7);
    rd_chk("co_wr_count", R_COUNT, 16'd7);
    step(3);
    rd_chk("co_k23_count", R_COUNT, 16'd7);
    step(1);
    rd_chk("co_k24_count", R_COUNT, 16'd6);
    wr(R_CTRL, 16'd0);
    wr(R_STATUS, 16'd3);
    rd_chk("co_end_status", R_STATUS, 16'd0);

`ifdef IO_TIMER_IRQ_EN
    // IRQ follows DONE by one cycle on both edges
    wr(R_LOAD, 16'd1);
    wr(R_COUNT, 16'd1);
    wr(R_CTRL, 16'd5);
    step(3);
    irq_chk("irq_k3", 1'b0);
    done_chk("irq_k3_done", 1'b0);
    step(1);
    done_chk("irq_k4_done", 1'b1);
    irq_chk("irq_k4", 1'b0);
    step(1);
    irq_chk("irq_k5", 1'b1);
    wr(R_STATUS, 16'd1);
    done_chk("irq_clr_done", 1'b0);
    irq_chk("irq_clr_k6", 1'b1);
    step(1);
    irq_chk("irq_clr_k7", 1'b0);
`endif

    // Reset mid-count
    wr(R_LOAD, 16'd5);
    wr(R_COUNT, 16'd5);
    wr(R_CTRL, 16'd1);
    step(2);
    rd_chk("mr_pre_count", R_COUNT, 16'd5);
    #1;
    reset = 1'b0;
    rd_chk("mr_count", R_COUNT, 16'd0);
    rd_chk("mr_ctrl", R_CTRL, 16'd0);
    rd_chk("mr_load", R_LOAD, 16'd0);
    rd_chk("mr_status", R_STATUS, 16'd0);
    done_chk("mr_done", 1'b0);
    step(2);
    reset = 1'b1;
    step(30);
    rd_chk("mr_after_count", R_COUNT, 16'd0);
    rd_chk("mr_after_status", R_STATUS, 16'd0);
    rd_chk("mr_after_ctrl", R_CTRL, 16'd0);
    done_chk("mr_after_done", 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
